mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch side and the data side of one core.
- Fetch side: PC-driven iREN/iaddr, consumes ihit to advance the PC. Data side: load/store requests from the memory stage.
- Data has priority, bounded by a starvation counter so fetch always makes progress.
- Generates the ihit/dhit pulses that gate PC update and pipeline advance.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Fetch, data and RAM-port signal bundle shared by the arbiter and its users.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        derr;
  logic        halt;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output iload, ihit, dload, dhit, derr, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    input  iload, ihit, dload, dhit, derr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one RAM port between fetch and data; data wins, bounded by starvation count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  wire logic    CLK,
  input  wire logic    nRST,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] STATE_IDLE   = 2'd0;
  localparam logic [1:0] STATE_DGRANT = 2'd1;
  localparam logic [1:0] STATE_IGRANT = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic w_d_req;
  logic w_force_i;
  logic w_access;
  logic w_error;

  assign w_d_req   = bus.dREN | bus.dWEN;
  assign w_force_i = bus.iREN & ~bus.halt & (starve_cnt_q == STARVE_LIMIT);
  assign w_access  = (bus.ramstate == RAM_ACCESS);
  assign w_error   = (bus.ramstate == RAM_ERROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= STATE_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    case (state_q)
      STATE_IDLE: begin
        if (w_d_req && !w_force_i)          state_d = STATE_DGRANT;
        else if (bus.iREN && !bus.halt)     state_d = STATE_IGRANT;
      end
      STATE_DGRANT: begin
        if (!w_d_req) begin
          state_d = STATE_IDLE;
        end else if (w_access) begin
          state_d = STATE_IDLE;
          // Only data grants that actually kept fetch waiting count toward starvation.
          if (!bus.iREN)                         starve_cnt_d = '0;
          else if (starve_cnt_q != STARVE_LIMIT) starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end else if (w_error) begin
          state_d = STATE_IDLE;
        end
      end
      STATE_IGRANT: begin
        if (!bus.iREN) begin
          state_d = STATE_IDLE;
        end else if (w_access) begin
          state_d      = STATE_IDLE;
          starve_cnt_d = '0;
        end else if (w_error) begin
          state_d = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.ihit     = 1'b0;
    bus.iload    = '0;
    bus.dhit     = 1'b0;
    bus.dload    = '0;
    bus.derr     = 1'b0;
    case (state_q)
      STATE_DGRANT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        if (w_d_req && w_access) begin
          bus.dhit  = 1'b1;
          bus.dload = bus.ramload;
        end else if (w_d_req && w_error) begin
          bus.derr = 1'b1;
        end
      end
      STATE_IGRANT: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        if (bus.iREN && w_access) begin
          bus.ihit  = 1'b1;
          bus.iload = bus.ramload;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter against a wait-state RAM model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam logic [1:0] RAM_FREE   = 2'b00;
  localparam logic [1:0] RAM_BUSY   = 2'b01;
  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;

  localparam logic [1:0] EV_I = 2'd0;
  localparam logic [1:0] EV_D = 2'd1;
  localparam logic [1:0] EV_E = 2'd2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // RAM model: wait_cfg BUSY cycles, then ACCESS (or ERROR when err_mode).
  logic [31:0] mem [0:255];
  int          wait_cfg = 0;
  bit          err_mode = 1'b0;
  int          busy_cnt = 0;

  always_comb begin
    if (!(bus.ramREN | bus.ramWEN)) bus.ramstate = RAM_FREE;
    else if (busy_cnt < wait_cfg)   bus.ramstate = RAM_BUSY;
    else if (err_mode)              bus.ramstate = RAM_ERROR;
    else                            bus.ramstate = RAM_ACCESS;
    bus.ramload = mem[bus.ramaddr[9:2]];
  end

  always @(posedge CLK) begin
    if ((bus.ramREN | bus.ramWEN) && bus.ramstate == RAM_BUSY) busy_cnt <= busy_cnt + 1;
    else                                                       busy_cnt <= 0;
    if (bus.ramWEN && bus.ramstate == RAM_ACCESS) mem[bus.ramaddr[9:2]] <= bus.ramstore;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  function automatic void push_exp(input logic [1:0] k, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  // Monitor: pops one expected event per completion pulse.
  logic [1:0]  mon_kind;
  logic [31:0] mon_data;
  exp_t        mon_exp;

  always @(negedge CLK) begin
    if (nRST) begin
      check("hit_exclusive", {31'b0, bus.ihit & bus.dhit}, 32'd0);
      if (!bus.ihit) check("iload_when_idle", bus.iload, 32'd0);
      if (!bus.dhit) check("dload_when_idle", bus.dload, 32'd0);
      if (bus.ihit | bus.dhit | bus.derr) begin
        mon_kind = bus.ihit ? EV_I : (bus.dhit ? EV_D : EV_E);
        mon_data = bus.ihit ? bus.iload : bus.dload;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual_kind=%0d required=none", mon_kind);
        end else begin
          mon_exp = exp_q.pop_front();
          check("event_kind", {30'b0, mon_kind}, {30'b0, mon_exp.kind});
          check("event_data", mon_data, mon_exp.data);
        end
      end
    end
  end

  task automatic wait_for(input logic [1:0] which, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      case (which)
        EV_I:    seen = bus.ihit;
        EV_D:    seen = bus.dhit;
        default: seen = bus.derr;
      endcase
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s actual=timeout required=pulse", nm);
    end
  endtask

  task automatic next_drive();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]  = 32'h8C010004;
    mem[16] = 32'h11112222;   // 0x40
    mem[64] = 32'h33334444;   // 0x100

    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.halt = 0;

    // Reset values
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ramREN", {31'b0, bus.ramREN}, 0);
    check("rst_ramWEN", {31'b0, bus.ramWEN}, 0);
    check("rst_hits",   {29'b0, bus.ihit, bus.dhit, bus.derr}, 0);
    check("rst_ramaddr", bus.ramaddr, 0);
    check("rst_ramstore", bus.ramstore, 0);
    @(negedge CLK);
    nRST = 1'b1;
    next_drive();

    // 1: zero-wait fetch
    bus.iREN = 1; bus.iaddr = 32'h0;
    push_exp(EV_I, 32'h8C010004);
    @(negedge CLK);
    check("t1_idle_ramREN", {31'b0, bus.ramREN}, 0);
    @(negedge CLK);
    check("t1_ramREN", {31'b0, bus.ramREN}, 1);
    check("t1_ramaddr", bus.ramaddr, 32'h0);
    check("t1_ihit", {31'b0, bus.ihit}, 1);
    check("t1_iload", bus.iload, 32'h8C010004);
    next_drive();
    bus.iREN = 0;
    @(negedge CLK);
    check("t1_back_idle", {30'b0, bus.ramREN, bus.ihit}, 0);
    next_drive();

    // 2: data first, then fetch
    bus.iREN = 1; bus.iaddr = 32'h40; bus.dREN = 1; bus.daddr = 32'h100;
    push_exp(EV_D, 32'h33334444);
    push_exp(EV_I, 32'h11112222);
    wait_for(EV_D, "t2_dhit");
    next_drive();
    bus.dREN = 0;
    wait_for(EV_I, "t2_ihit");
    next_drive();
    bus.iREN = 0;

    // 3: starvation bound: 4 data, 1 fetch, data resumes
    for (int k = 0; k < 4; k++) push_exp(EV_D, 32'h33334444);
    push_exp(EV_I, 32'h11112222);
    push_exp(EV_D, 32'h33334444);
    bus.iREN = 1; bus.iaddr = 32'h40; bus.dREN = 1; bus.daddr = 32'h100;
    n = 0;
    for (int i = 0; i < 100 && n < 6; i++) begin
      @(negedge CLK);
      if (bus.ihit | bus.dhit) n++;
    end
    check("t3_event_count", n, 6);
    next_drive();
    bus.iREN = 0; bus.dREN = 0;
    next_drive();

    // 4: write with 3 BUSY cycles, then read back
    wait_cfg = 3;
    bus.dWEN = 1; bus.dREN = 1; bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
    push_exp(EV_D, 32'h0);
    @(negedge CLK);
    check("t4_idle_ramWEN", {31'b0, bus.ramWEN}, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check("t4_ramWEN", {31'b0, bus.ramWEN}, 1);
      check("t4_ramREN", {31'b0, bus.ramREN}, 0);
      check("t4_ramstore", bus.ramstore, 32'hDEADBEEF);
      check("t4_ramaddr", bus.ramaddr, 32'h200);
      check("t4_dhit", {31'b0, bus.dhit}, (k == 4) ? 1 : 0);
    end
    next_drive();
    bus.dWEN = 0; bus.dREN = 0; wait_cfg = 0;
    next_drive();
    bus.dREN = 1; bus.daddr = 32'h200;
    push_exp(EV_D, 32'hDEADBEEF);
    wait_for(EV_D, "t4_readback");
    next_drive();
    bus.dREN = 0;

    // 5: halt during in-flight fetch
    wait_cfg = 2;
    bus.iREN = 1; bus.iaddr = 32'h0;
    push_exp(EV_I, 32'h8C010004);
    next_drive();
    bus.halt = 1;
    wait_for(EV_I, "t5_inflight_ihit");
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      if (bus.ihit | bus.ramREN) n++;
    end
    check("t5_halt_blocks_fetch", n, 0);
    next_drive();
    bus.dWEN = 1; bus.daddr = 32'h204; bus.dstore = 32'h12345678;
    push_exp(EV_D, 32'h0);
    wait_for(EV_D, "t5_halt_dhit");
    next_drive();
    bus.dWEN = 0; bus.iREN = 0; bus.halt = 0; wait_cfg = 0;
    next_drive();

    // 6: reset mid-access, then ERROR on data
    wait_cfg = 5;
    bus.dREN = 1; bus.daddr = 32'h100;
    @(negedge CLK);
    @(negedge CLK);
    check("t6_granted", {31'b0, bus.ramREN}, 1);
    #1 nRST = 1'b0;
    #1;
    check("t6_rst_ramREN", {31'b0, bus.ramREN}, 0);
    check("t6_rst_ramaddr", bus.ramaddr, 0);
    check("t6_rst_dhit", {31'b0, bus.dhit}, 0);
    bus.dREN = 0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    wait_cfg = 0;
    @(negedge CLK);
    check("t6_post_rst_idle", {31'b0, bus.ramREN}, 0);
    next_drive();
    bus.dREN = 1; bus.daddr = 32'h100;
    push_exp(EV_D, 32'h33334444);
    wait_for(EV_D, "t6_rearb_dhit");
    next_drive();
    bus.dREN = 0;
    next_drive();
    err_mode = 1;
    bus.dREN = 1; bus.daddr = 32'h40;
    push_exp(EV_E, 32'h0);
    wait_for(EV_E, "t6_derr");
    check("t6_err_no_dhit", {31'b0, bus.dhit}, 0);
    next_drive();
    bus.dREN = 0; err_mode = 0;

    repeat (3) @(negedge CLK);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
